// File: rtl/regfile_wb.sv
// Writeback stage: merges ALU and load results onto the register file's single
// write port, buffers loads in a small FIFO, and tracks pending writes per register.
module regfile_wb #(
  parameter int LDQ_DEPTH = 2,
  parameter int LDQ_AW    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_sel,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_sel,
  input  logic [31:0] ld_data,
  input  logic        iss_valid,
  input  logic [3:0]  iss_sel,
  output logic        iss_conflict,
  output logic [15:0] busy,
  output logic        we,
  output logic [3:0]  wsel,
  output logic [31:0] wdata
);

  localparam logic [3:0]        ZERO_REG = 4'd15;
  localparam logic [LDQ_AW:0]   LDQ_FULL = (LDQ_AW + 1)'(LDQ_DEPTH);

  // Load handshake: a transfer happens at the rising edge where ld_valid and
  // ld_ready are both high; ld_ready depends only on the current fill level,
  // never on ld_valid or on a pop in the same cycle.

  logic [31:0]       ldq_data [LDQ_DEPTH];
  logic [3:0]        ldq_sel  [LDQ_DEPTH];
  logic [LDQ_AW-1:0] wr_ptr;
  logic [LDQ_AW-1:0] rd_ptr;
  logic [LDQ_AW:0]   count;

  logic        alu_take;
  logic        ld_fire;
  logic        push;
  logic        pop;
  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic [15:0] busy_nxt;

  assign ld_ready = !reset && (count < LDQ_FULL);
  assign ld_fire  = ld_valid && ld_ready;
  assign alu_take = alu_valid && (alu_sel != ZERO_REG);
  // Loads to the zero register complete the handshake but never enter the queue.
  assign push     = ld_fire && (ld_sel != ZERO_REG);
  assign pop      = !alu_take && (count != '0);

  assign iss_conflict = iss_valid && busy[iss_sel];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && (iss_sel != ZERO_REG)) set_vec = 16'b1 << iss_sel;
    if (we) clr_vec = 16'b1 << wsel;
    // Set is applied after clear so a same-edge re-issue keeps the bit busy.
    busy_nxt = ((busy & ~clr_vec) | set_vec) & 16'h7fff;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ldq_data[wr_ptr] <= ld_data;
      ldq_sel[wr_ptr]  <= ld_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LDQ_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + LDQ_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (LDQ_AW + 1)'(1);
        2'b01:   count <= count - (LDQ_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we    <= 1'b0;
      wsel  <= '0;
      wdata <= '0;
      busy  <= '0;
    end else begin
      busy <= busy_nxt;
      if (alu_take) begin
        we    <= 1'b1;
        wsel  <= alu_sel;
        wdata <= alu_data;
      end else if (pop) begin
        we    <= 1'b1;
        wsel  <= ldq_sel[rd_ptr];
        wdata <= ldq_data[rd_ptr];
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Writeback stage directly upstream of the dual-read/single-write register file.
- Merges results from the single-cycle ALU and the multi-cycle load unit onto the register file's one write port (we/wsel/wdata).
- Buffers loads in a small FIFO when the ALU holds the port.
- Keeps a per-register pending-write scoreboard that the issue stage uses to detect hazards.
- Register 15 is the hardwired zero register and is never written or marked busy.

Parameters:
- LDQ_DEPTH, 2, load result FIFO depth in entries (power of 2, >=2).
- LDQ_AW, 1, log2(LDQ_DEPTH), the FIFO pointer width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- alu_valid  input  1  ALU result valid this cycle; no backpressure.
- alu_sel  input  4  ALU destination register.
- alu_data  input  32  ALU result.
- ld_valid  input  1  load result offered.
- ld_ready  output  1  load result accepted when ld_valid & ld_ready at clock edge.
- ld_sel  input  4  load destination register.
- ld_data  input  32  load data.
- iss_valid  input  1  issue stage dispatching an instruction with a destination.
- iss_sel  input  4  that destination register.
- iss_conflict  output  1  combinational: iss_valid & busy[iss_sel].
- busy  output  16  registered scoreboard; bit n=1 means a write to Rn is pending.
- we  output  1  register file write enable (registered).
- wsel  output  4  register file write select (registered).
- wdata  output  32  register file write data (registered).

Behaviour:
- Reset (async): we=0, wsel=0, wdata=0, busy=0, FIFO empty (pointers and count 0). ld_ready=0 while reset is high.
- Port arbitration, evaluated each cycle, result registered at the edge:
  - 1) alu_valid & alu_sel!=15 -> we<=1, wsel<=alu_sel, wdata<=alu_data.
  - 2) else FIFO not empty -> pop head, we<=1, wsel/wdata<=head.
  - 3) else we<=0; wsel and wdata hold their previous values.
- Latency: a result accepted in cycle n drives we in cycle n+1; the register file captures it at the end of cycle n+1.
- An ALU result with alu_sel==15 is discarded. It does not occupy the port, so the FIFO head may drain that cycle.
- Load FIFO:
  - ld_ready = (count < LDQ_DEPTH), based only on the current count. A same-cycle pop does not make a full FIFO ready.
  - A load handshake with ld_sel==15 is accepted and dropped; it is not enqueued.
  - Simultaneous push and pop: count unchanged, both pointers advance and wrap mod LDQ_DEPTH.
  - Order is strictly FIFO.
  - A load is never lost while the ALU owns the port; the ALU can starve the FIFO indefinitely.
- Scoreboard:
  - Set: iss_valid & iss_sel!=15 sets busy[iss_sel] at the edge.
  - Clear: busy[x] is cleared at the edge ending a cycle in which we=1 & wsel==x, i.e. the same edge at which the register file captures the write.
  - Same register set and cleared at the same edge -> set wins (busy stays 1).
  - busy[15] is always 0.
  - Issuing to a register that is already busy is a protocol error. iss_conflict flags it, and the scoreboard takes no other action.
- Reset mid-operation: FIFO contents and pending busy bits are discarded; no write occurs after reset deasserts until a new result arrives.

Test Plan:
- ALU only: alu_valid=1, sel=3, data=0xDEADBEEF in cycle 0 -> cycle 1 has we=1, wsel=3, wdata=0xDEADBEEF; cycle 2 has we=0 when idle.
- Load vs ALU conflict, FIFO fill:
  - ALU valid for 4 consecutive cycles (sel 1..4); loads offered every cycle with sel 5,6,7.
  - Loads 5 and 6 are accepted; ld_ready drops while count=2.
  - After the ALU idles, writes 5, 6, 7 appear in order on consecutive cycles.
- Zero register:
  - alu_sel=15 with a queued load sel=8 -> load 8 is written in the next cycle; we never asserts with wsel=15.
  - ld_sel=15 is accepted, never written.
  - iss_sel=15 leaves busy=0.
- Scoreboard:
  - iss_valid sel=9 -> busy[9]=1 next cycle.
  - Load to 9 accepted -> busy[9] clears one cycle after we&wsel==9.
  - Re-issue to 9 on that same clear edge -> busy[9] stays 1.
  - iss_sel=9 while busy -> iss_conflict=1.
- Async reset: assert reset mid-cycle with FIFO count=2 and busy=0x0202 -> we, busy, wdata read 0 immediately; after release, no spurious write and ld_ready=1.
